// File: rtl/simple2axi_master_pkg.sv
// Shared AXI-Lite response encodings and protection default for the simple-bus
// to AXI-Lite master bridge.
package simple2axi_master_pkg;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } axi_resp_e;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return axi_resp_e'(resp) != AXI_OKAY;
    endfunction

endpackage

// File: rtl/simple2axi_master_if.sv
// Simple-bus request/response plus AXI-Lite master channels seen by the bridge.
// The master modport is the bridge; the slave modport is the requester plus AXI slave side.
interface simple2axi_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              s_valid;
    logic              s_write;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_ready;
    logic              s_rvalid;
    logic [DATA_W-1:0] s_rdata;
    logic              s_err;

    logic              m_awvalid;
    logic              m_awready;
    logic [ADDR_W-1:0] m_awaddr;
    logic [2:0]        m_awprot;
    logic              m_wvalid;
    logic              m_wready;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic              m_bvalid;
    logic              m_bready;
    logic [1:0]        m_bresp;
    logic              m_arvalid;
    logic              m_arready;
    logic [ADDR_W-1:0] m_araddr;
    logic [2:0]        m_arprot;
    logic              m_rvalid;
    logic              m_rready;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;

    modport master (
        input  s_valid, s_write, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rvalid, s_rdata, s_err,
        output m_awvalid, m_awaddr, m_awprot, input m_awready,
        output m_wvalid, m_wdata, m_wstrb, input m_wready,
        input  m_bvalid, m_bresp, output m_bready,
        output m_arvalid, m_araddr, m_arprot, input m_arready,
        input  m_rvalid, m_rdata, m_rresp, output m_rready
    );

    modport slave (
        output s_valid, s_write, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rvalid, s_rdata, s_err,
        input  m_awvalid, m_awaddr, m_awprot, output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, output m_wready,
        output m_bvalid, m_bresp, input m_bready,
        input  m_arvalid, m_araddr, m_arprot, output m_arready,
        output m_rvalid, m_rdata, m_rresp, input m_rready
    );

endinterface

// File: rtl/simple2axi_master.sv
// Single-outstanding simple-bus to AXI-Lite master bridge; every AXI valid/ready
// and every simple-bus response output is a flop, so no path runs from m_*ready.
module simple2axi_master
    import simple2axi_master_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    simple2axi_master_if.master bus
);
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              s_ready_q, s_ready_d;
    logic              s_rvalid_q, s_rvalid_d;
    logic              s_err_q, s_err_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        s_ready_d  = 1'b0;
        s_rvalid_d = 1'b0;
        s_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    addr_d    = bus.s_addr;
                    wdata_d   = bus.s_wdata;
                    wstrb_d   = bus.s_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (bus.s_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; leave only once both have handshaken.
                if (awvalid_q && bus.m_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && bus.m_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.m_bvalid) begin
                    bready_d  = 1'b0;
                    s_ready_d = 1'b1;
                    s_err_d   = resp_is_err(bus.m_bresp);
                    state_d   = DONE;
                end
            end
            RD_REQ: begin
                if (bus.m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus.m_rvalid) begin
                    rready_d   = 1'b0;
                    rdata_d    = bus.m_rdata;
                    s_ready_d  = 1'b1;
                    s_rvalid_d = 1'b1;
                    s_err_d    = resp_is_err(bus.m_rresp);
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            s_ready_q  <= 1'b0;
            s_rvalid_q <= 1'b0;
            s_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            s_ready_q  <= s_ready_d;
            s_rvalid_q <= s_rvalid_d;
            s_err_q    <= s_err_d;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.s_rvalid  = s_rvalid_q;
    assign bus.s_rdata   = rdata_q;
    assign bus.s_err     = s_err_q;
    assign bus.m_awvalid = awvalid_q;
    assign bus.m_awaddr  = addr_q;
    assign bus.m_awprot  = AXI_PROT_DEFAULT;
    assign bus.m_wvalid  = wvalid_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = wstrb_q;
    assign bus.m_bready  = bready_q;
    assign bus.m_arvalid = arvalid_q;
    assign bus.m_araddr  = addr_q;
    assign bus.m_arprot  = AXI_PROT_DEFAULT;
    assign bus.m_rready  = rready_q;

endmodule

// File: tb/tb_simple2axi_master.sv
// Self-checking bench: a stallable AXI-Lite slave/RAM model on the master side and a
// simple-bus requester, with expected latency, status and data derived from the bridge rules.
module tb_simple2axi_master;
    import simple2axi_master_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    simple2axi_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    simple2axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int fails  = 0;

    // Slave model configuration (written by the test sequence, read by the slave process).
    int         cfg_aw_delay = 0, cfg_w_delay = 0, cfg_b_delay = 0;
    int         cfg_ar_delay = 0, cfg_r_delay = 0;
    logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    bit         cfg_regfile = 1'b0;

    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] slv_rf  [logic [2:0]];
    logic [31:0] exp_mem [logic [31:0]];

    int wr_count = 0, aw_fires = 0, w_fires = 0, ar_fires = 0;
    int aw_fire_cyc = 0, w_fire_cyc = 0, cyc = 0, viol = 0;

    function automatic logic [31:0] slv_read(input logic [31:0] a);
        if (cfg_regfile) return slv_rf.exists(a[4:2]) ? slv_rf[a[4:2]] : 32'h0;
        return slv_mem.exists(a[31:2]) ? slv_mem[a[31:2]] : 32'h0;
    endfunction

    function automatic void slv_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w = slv_read(a);
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        if (cfg_regfile) slv_rf[a[4:2]] = w;
        else slv_mem[a[31:2]] = w;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        return exp_mem.exists(a >> 2) ? exp_mem[a >> 2] : 32'h0;
    endfunction

    function automatic void exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        exp_mem[a >> 2] = (exp_read(a) & ~mask) | (d & mask);
    endfunction

    function automatic logic [139:0] get_outs();
        return {bus.s_ready, bus.s_rvalid, bus.s_err, bus.s_rdata, bus.m_awvalid, bus.m_wvalid,
                bus.m_bready, bus.m_arvalid, bus.m_rready, bus.m_awaddr, bus.m_wdata,
                bus.m_wstrb, bus.m_araddr};
    endfunction

    // AXI-Lite slave: decides at each falling edge what it drives for the next rising edge;
    // a handshake committed at one falling edge takes effect at the following one.
    initial begin
        logic        aw_fire, w_fire, b_fire, ar_fire, r_fire;
        logic        aw_got, w_got, b_pend, r_pend;
        int          aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
        logic [31:0] aw_addr_l, w_data_l, ar_addr_l, r_data_l;
        logic [3:0]  w_strb_l;
        logic        p_awv, p_wv, p_arv;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
        aw_addr_l = '0; w_data_l = '0; ar_addr_l = '0; r_data_l = '0; w_strb_l = '0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0;
        bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = '0;
        bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = '0; bus.m_rresp = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                p_awv = 0; p_wv = 0; p_arv = 0;
                bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;
                bus.m_arready = 0; bus.m_rvalid = 0;
            end else begin
                if (p_awv && !aw_fire && (!bus.m_awvalid || bus.m_awaddr !== p_awaddr)) viol++;
                if (p_wv && !w_fire && (!bus.m_wvalid || bus.m_wdata !== p_wdata || bus.m_wstrb !== p_wstrb)) viol++;
                if (p_arv && !ar_fire && (!bus.m_arvalid || bus.m_araddr !== p_araddr)) viol++;
                if (bus.m_bready && bus.m_rready) viol++;

                if (aw_fire) begin aw_got = 1; aw_fires++; aw_fire_cyc = cyc; aw_cnt = 0; end
                if (w_fire)  begin w_got = 1; w_fires++; w_fire_cyc = cyc; w_cnt = 0; end
                if (aw_got && w_got) begin
                    slv_write(aw_addr_l, w_data_l, w_strb_l);
                    wr_count++;
                    aw_got = 0; w_got = 0; b_pend = 1; b_wait = cfg_b_delay;
                end
                if (b_fire) b_pend = 0;
                if (ar_fire) begin
                    ar_fires++; ar_cnt = 0; r_pend = 1; r_wait = cfg_r_delay;
                    r_data_l = slv_read(ar_addr_l);
                end
                if (r_fire) r_pend = 0;

                bus.m_awready = 0;
                if (bus.m_awvalid && !aw_got) begin
                    if (aw_cnt >= cfg_aw_delay) bus.m_awready = 1; else aw_cnt++;
                end
                bus.m_wready = 0;
                if (bus.m_wvalid && !w_got) begin
                    if (w_cnt >= cfg_w_delay) bus.m_wready = 1; else w_cnt++;
                end
                bus.m_arready = 0;
                if (bus.m_arvalid) begin
                    if (ar_cnt >= cfg_ar_delay) bus.m_arready = 1; else ar_cnt++;
                end
                bus.m_bvalid = 0;
                if (b_pend) begin
                    if (b_wait > 0) b_wait--;
                    else begin bus.m_bvalid = 1; bus.m_bresp = cfg_bresp; end
                end
                bus.m_rvalid = 0;
                if (r_pend) begin
                    if (r_wait > 0) r_wait--;
                    else begin bus.m_rvalid = 1; bus.m_rdata = r_data_l; bus.m_rresp = cfg_rresp; end
                end

                aw_fire = bus.m_awvalid && bus.m_awready;
                w_fire  = bus.m_wvalid && bus.m_wready;
                ar_fire = bus.m_arvalid && bus.m_arready;
                b_fire  = bus.m_bvalid && bus.m_bready;
                r_fire  = bus.m_rvalid && bus.m_rready;
                if (aw_fire) aw_addr_l = bus.m_awaddr;
                if (w_fire) begin w_data_l = bus.m_wdata; w_strb_l = bus.m_wstrb; end
                if (ar_fire) ar_addr_l = bus.m_araddr;
                p_awv = bus.m_awvalid; p_awaddr = bus.m_awaddr;
                p_wv = bus.m_wvalid; p_wdata = bus.m_wdata; p_wstrb = bus.m_wstrb;
                p_arv = bus.m_arvalid; p_araddr = bus.m_araddr;
            end
        end
    end

    // Requester: called at a falling edge, returns one falling edge after the s_ready pulse.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                          output logic rvalid, output int lat, output logic pulse_after,
                          output logic timeout);
        bus.s_valid = 1; bus.s_write = wr; bus.s_addr = addr; bus.s_wdata = wdata; bus.s_wstrb = wstrb;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.s_ready && lat < 100);
        timeout = !bus.s_ready;
        rdata = bus.s_rdata; err = bus.s_err; rvalid = bus.s_rvalid;
        bus.s_valid = 0;
        @(negedge clk);
        pulse_after = bus.s_ready | bus.s_rvalid;
    endtask

    logic [31:0] rd;
    logic        er, rv, pa, to;
    int          lat;

    task automatic test_reset();
        rst_n = 0;
        #1;
        checks++; if (get_outs() !== '0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", get_outs()); end
        checks++; if ({bus.m_awprot, bus.m_arprot} !== {AXI_PROT_DEFAULT, AXI_PROT_DEFAULT}) begin
            fails++; $display("FAIL prot: got %b/%b expected 000", bus.m_awprot, bus.m_arprot); end
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++; if (get_outs() !== '0) begin fails++; $display("FAIL idle_outputs: got %h expected 0", get_outs()); end
    endtask

    task automatic test_basic_write();
        do_txn(1, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF, rd, er, rv, lat, pa, to);
        checks++; if (to !== 0) begin fails++; $display("FAIL wr_timeout: no s_ready within budget"); end
        checks++; if (lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d expected 3", lat); end
        checks++; if ({er, rv} !== 2'b00) begin fails++; $display("FAIL wr_status: err=%b rvalid=%b expected 0/0", er, rv); end
        checks++; if (pa !== 0) begin fails++; $display("FAIL wr_pulse: s_ready/s_rvalid still high next cycle"); end
        checks++; if (slv_read(32'h4000_0000) !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL wr_ram: got %h expected deadbeef", slv_read(32'h4000_0000)); end
        exp_write(32'h4000_0000, 32'hDEAD_BEEF, 4'hF);
    endtask

    task automatic test_basic_read();
        do_txn(0, 32'h4000_0000, 32'h0, 4'h0, rd, er, rv, lat, pa, to);
        checks++; if (to !== 0) begin fails++; $display("FAIL rd_timeout: no s_ready within budget"); end
        checks++; if (lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        checks++; if ({rv, er} !== 2'b10) begin fails++; $display("FAIL rd_status: rvalid=%b err=%b expected 1/0", rv, er); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        checks++; if (pa !== 0) begin fails++; $display("FAIL rd_pulse: s_ready/s_rvalid still high next cycle"); end
        checks++; if (bus.s_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_hold: got %h expected deadbeef", bus.s_rdata); end
    endtask

    task automatic test_unbalanced();
        for (int k = 0; k < 2; k++) begin
            int wc0 = wr_count, aw0 = aw_fires, w0 = w_fires;
            logic w_first;
            cfg_aw_delay = (k == 0) ? 3 : 0;
            cfg_w_delay  = (k == 0) ? 0 : 3;
            do_txn(1, 32'h4000_0010 + 32'(4 * k), 32'h1234_5678, 4'hF, rd, er, rv, lat, pa, to);
            w_first = (w_fire_cyc < aw_fire_cyc);
            checks++; if (lat !== 6 || to !== 0) begin fails++; $display("FAIL unbal%0d_latency: got %0d expected 6", k, lat); end
            checks++; if (w_first !== (k == 0)) begin
                fails++; $display("FAIL unbal%0d_order: w_cyc=%0d aw_cyc=%0d w_first expected %0d", k, w_fire_cyc, aw_fire_cyc, k == 0); end
            checks++; if ({wr_count - wc0, aw_fires - aw0, w_fires - w0} !== {32'd1, 32'd1, 32'd1}) begin
                fails++; $display("FAIL unbal%0d_once: writes=%0d aw=%0d w=%0d expected 1/1/1", k, wr_count - wc0, aw_fires - aw0, w_fires - w0); end
            checks++; if (slv_read(32'h4000_0010 + 32'(4 * k)) !== 32'h1234_5678) begin
                fails++; $display("FAIL unbal%0d_ram: got %h expected 12345678", k, slv_read(32'h4000_0010 + 32'(4 * k))); end
        end
        cfg_aw_delay = 0; cfg_w_delay = 0;
    endtask

    task automatic test_partial_strobe();
        do_txn(1, 32'h4000_000C, 32'hFFFF_FFFF, 4'hF, rd, er, rv, lat, pa, to);
        do_txn(1, 32'h4000_000C, 32'h0000_00AB, 4'b0001, rd, er, rv, lat, pa, to);
        do_txn(0, 32'h4000_000C, 32'h0, 4'h0, rd, er, rv, lat, pa, to);
        checks++; if (rd !== 32'hFFFF_FFAB || to !== 0) begin fails++; $display("FAIL strobe_data: got %h expected ffffffab", rd); end
    endtask

    task automatic test_error_resp();
        cfg_bresp = AXI_SLVERR;
        do_txn(1, 32'h4000_0008, 32'h1111_2222, 4'hF, rd, er, rv, lat, pa, to);
        checks++; if ({er, rv, to} !== 3'b100 || lat !== 3) begin
            fails++; $display("FAIL bresp_err: err=%b rvalid=%b lat=%0d expected 1/0/3", er, rv, lat); end
        cfg_bresp = AXI_OKAY; cfg_rresp = AXI_DECERR;
        do_txn(0, 32'h4000_0008, 32'h0, 4'h0, rd, er, rv, lat, pa, to);
        checks++; if ({er, rv, to} !== 3'b110) begin fails++; $display("FAIL rresp_err: err=%b rvalid=%b expected 1/1", er, rv); end
        checks++; if (rd !== 32'h1111_2222) begin fails++; $display("FAIL rresp_data: got %h expected 11112222", rd); end
        cfg_rresp = AXI_OKAY;
        do_txn(0, 32'h4000_0008, 32'h0, 4'h0, rd, er, rv, lat, pa, to);
        checks++; if ({er, rv, to} !== 3'b010) begin fails++; $display("FAIL err_recover: err=%b rvalid=%b expected 0/1", er, rv); end
    endtask

    task automatic test_reset_mid_write();
        logic seen = 0;
        do_txn(1, 32'h4000_0004, 32'h0BAD_F00D, 4'hF, rd, er, rv, lat, pa, to);
        cfg_b_delay = 8;
        bus.s_valid = 1; bus.s_write = 1; bus.s_addr = 32'h4000_0020; bus.s_wdata = 32'h5555_AAAA; bus.s_wstrb = 4'hF;
        for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); seen = bus.m_bready; end
        checks++; if (seen !== 1) begin fails++; $display("FAIL mid_reach_wr_resp: m_bready=%b expected 1", seen); end
        bus.s_valid = 0;
        rst_n = 0;
        #1;
        checks++; if (get_outs() !== '0) begin fails++; $display("FAIL mid_reset_outputs: got %h expected 0", get_outs()); end
        repeat (2) @(negedge clk);
        rst_n = 1; cfg_b_delay = 0;
        @(negedge clk);
        do_txn(0, 32'h4000_0004, 32'h0, 4'h0, rd, er, rv, lat, pa, to);
        checks++; if (rd !== 32'h0BAD_F00D || {er, rv, to} !== 3'b010 || lat !== 3) begin
            fails++; $display("FAIL mid_after_read: data=%h err=%b rvalid=%b lat=%0d expected 0badf00d/0/1/3", rd, er, rv, lat); end
    endtask

    task automatic test_loopback_regfile();
        cfg_regfile = 1;
        do_txn(1, 32'h0000_0004, 32'hCAFE_1234, 4'hF, rd, er, rv, lat, pa, to);
        do_txn(0, 32'h0000_0004, 32'h0, 4'h0, rd, er, rv, lat, pa, to);
        checks++; if (rd !== 32'hCAFE_1234 || {er, rv, to} !== 3'b010) begin
            fails++; $display("FAIL loopback: data=%h err=%b rvalid=%b expected cafe1234/0/1", rd, er, rv); end
        cfg_regfile = 0;
    endtask

    task automatic test_back_to_back_random();
        int          n_wr = 0, n_rd = 0, wc0 = wr_count, ar0 = ar_fires, v0 = viol;
        logic [31:0] last_rd = bus.s_rdata;
        for (int t = 0; t < 40; t++) begin
            logic        wr = 1'($urandom_range(0, 1));
            logic [31:0] a  = 32'h4000_0100 + 32'(4 * $urandom_range(0, 7));
            logic [31:0] d  = $urandom;
            logic [3:0]  s  = 4'($urandom_range(0, 15));
            logic [1:0]  resp = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            int          exp_lat;
            logic [31:0] exp_rd;
            cfg_aw_delay = $urandom_range(0, 3); cfg_w_delay = $urandom_range(0, 3);
            cfg_b_delay  = $urandom_range(0, 3); cfg_ar_delay = $urandom_range(0, 3);
            cfg_r_delay  = $urandom_range(0, 3);
            cfg_bresp = resp; cfg_rresp = resp;
            if (wr) begin
                exp_lat = 3 + ((cfg_aw_delay > cfg_w_delay) ? cfg_aw_delay : cfg_w_delay) + cfg_b_delay;
                exp_write(a, d, s);
                exp_rd = last_rd;
                n_wr++;
            end else begin
                exp_lat = 3 + cfg_ar_delay + cfg_r_delay;
                exp_rd = exp_read(a);
                last_rd = exp_rd;
                n_rd++;
            end
            do_txn(wr, a, d, s, rd, er, rv, lat, pa, to);
            checks++; if (to !== 0 || lat !== exp_lat) begin
                fails++; $display("FAIL rnd%0d_latency: got %0d expected %0d (wr=%b)", t, lat, exp_lat, wr); end
            checks++; if ({er, rv} !== {resp != 2'b00, !wr}) begin
                fails++; $display("FAIL rnd%0d_status: err=%b rvalid=%b expected %b/%b", t, er, rv, resp != 2'b00, !wr); end
            checks++; if (rd !== exp_rd) begin fails++; $display("FAIL rnd%0d_rdata: got %h expected %h (wr=%b)", t, rd, exp_rd, wr); end
            checks++; if (pa !== 0) begin fails++; $display("FAIL rnd%0d_pulse: s_ready/s_rvalid still high next cycle", t); end
        end
        checks++; if (wr_count - wc0 !== n_wr || ar_fires - ar0 !== n_rd) begin
            fails++; $display("FAIL rnd_counts: writes=%0d reads=%0d expected %0d/%0d", wr_count - wc0, ar_fires - ar0, n_wr, n_rd); end
        checks++; if (viol - v0 !== 0) begin fails++; $display("FAIL rnd_protocol: %0d valid/payload/ready violations expected 0", viol - v0); end
        cfg_aw_delay = 0; cfg_w_delay = 0; cfg_b_delay = 0; cfg_ar_delay = 0; cfg_r_delay = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    endtask

    initial begin
        rst_n = 0;
        bus.s_valid = 0; bus.s_write = 0; bus.s_addr = '0; bus.s_wdata = '0; bus.s_wstrb = '0;
        test_reset();
        test_basic_write();
        test_basic_read();
        test_unbalanced();
        test_partial_strobe();
        test_error_resp();
        test_reset_mid_write();
        test_loopback_regfile();
        test_back_to_back_random();
        checks++; if (viol !== 0) begin fails++; $display("FAIL protocol_total: %0d violations expected 0", viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
